// File: rtl/rx_commit_ptr_table.sv
// Per-flow receive commit-pointer table: 2R1W storage with an init-priority write
// port and two independent read ports, each with a one-entry snapshot response register.
`timescale 1ns/1ps

module rx_commit_ptr_table #(
    parameter int FLOWID_W         = 8,
    parameter int RX_PAYLOAD_PTR_W = 16
) (
    input  logic                        clk,
    input  logic                        rst,

    input  logic                        store_buf_commit_ptr_rd_req_val,
    input  logic [FLOWID_W-1:0]         store_buf_commit_ptr_rd_req_flowid,
    output logic                        commit_ptr_store_buf_rd_req_rdy,
    output logic                        commit_ptr_store_buf_rd_resp_val,
    output logic [RX_PAYLOAD_PTR_W:0]   commit_ptr_store_buf_rd_resp_data,
    input  logic                        store_buf_commit_ptr_rd_resp_rdy,

    input  logic                        store_buf_commit_ptr_wr_req_val,
    input  logic [FLOWID_W-1:0]         store_buf_commit_ptr_wr_req_flowid,
    input  logic [RX_PAYLOAD_PTR_W:0]   store_buf_commit_ptr_wr_req_data,
    output logic                        commit_ptr_store_buf_wr_req_rdy,

    input  logic                        app_commit_ptr_rd_req_val,
    input  logic [FLOWID_W-1:0]         app_commit_ptr_rd_req_flowid,
    output logic                        commit_ptr_app_rd_req_rdy,
    output logic                        commit_ptr_app_rd_resp_val,
    output logic [RX_PAYLOAD_PTR_W:0]   commit_ptr_app_rd_resp_data,
    input  logic                        app_commit_ptr_rd_resp_rdy,

    input  logic                        init_commit_ptr_wr_val,
    input  logic [FLOWID_W-1:0]         init_commit_ptr_wr_flowid,
    input  logic [RX_PAYLOAD_PTR_W:0]   init_commit_ptr_wr_data,
    output logic                        commit_ptr_init_wr_rdy
);

    localparam int PTR_W = RX_PAYLOAD_PTR_W + 1;
    localparam int DEPTH = 1 << FLOWID_W;
    localparam int NPORT = 2;

    logic [PTR_W-1:0]    mem_q [DEPTH];

    logic                wr_en;
    logic [FLOWID_W-1:0] wr_flowid;
    logic [PTR_W-1:0]    wr_data;

    // Init writes always win; the store-buf writer simply waits for a free cycle.
    assign commit_ptr_init_wr_rdy          = 1'b1;
    assign commit_ptr_store_buf_wr_req_rdy = ~init_commit_ptr_wr_val;

    always_comb begin
        wr_en = init_commit_ptr_wr_val | store_buf_commit_ptr_wr_req_val;
        if (init_commit_ptr_wr_val) begin
            wr_flowid = init_commit_ptr_wr_flowid;
            wr_data   = init_commit_ptr_wr_data;
        end else begin
            wr_flowid = store_buf_commit_ptr_wr_req_flowid;
            wr_data   = store_buf_commit_ptr_wr_req_data;
        end
    end

    // Entries are deliberately not reset; flow setup initialises them.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_flowid] <= wr_data;
        end
    end

    logic                rd_req_val    [NPORT];
    logic [FLOWID_W-1:0] rd_req_flowid [NPORT];
    logic                rd_resp_rdy   [NPORT];
    logic                rd_req_rdy    [NPORT];
    logic                rd_resp_val   [NPORT];
    logic [PTR_W-1:0]    rd_resp_data  [NPORT];

    assign rd_req_val[0]    = store_buf_commit_ptr_rd_req_val;
    assign rd_req_flowid[0] = store_buf_commit_ptr_rd_req_flowid;
    assign rd_resp_rdy[0]   = store_buf_commit_ptr_rd_resp_rdy;
    assign rd_req_val[1]    = app_commit_ptr_rd_req_val;
    assign rd_req_flowid[1] = app_commit_ptr_rd_req_flowid;
    assign rd_resp_rdy[1]   = app_commit_ptr_rd_resp_rdy;

    assign commit_ptr_store_buf_rd_req_rdy   = rd_req_rdy[0];
    assign commit_ptr_store_buf_rd_resp_val  = rd_resp_val[0];
    assign commit_ptr_store_buf_rd_resp_data = rd_resp_data[0];
    assign commit_ptr_app_rd_req_rdy         = rd_req_rdy[1];
    assign commit_ptr_app_rd_resp_val        = rd_resp_val[1];
    assign commit_ptr_app_rd_resp_data       = rd_resp_data[1];

    genvar gi;
    generate
        for (gi = 0; gi < NPORT; gi++) begin : g_rd_port
            logic             resp_val_q;
            logic             resp_val_d;
            logic [PTR_W-1:0] resp_data_q;
            logic [PTR_W-1:0] resp_data_d;
            logic             req_acc;
            logic             bypass;

            assign rd_req_rdy[gi] = ~resp_val_q | rd_resp_rdy[gi];
            assign req_acc        = rd_req_val[gi] & rd_req_rdy[gi];
            assign bypass         = wr_en & (wr_flowid == rd_req_flowid[gi]);

            // The response register is only loaded on acceptance, so a held
            // response is a snapshot unaffected by later writes.
            always_comb begin
                resp_val_d  = resp_val_q;
                resp_data_d = resp_data_q;
                if (req_acc) begin
                    resp_val_d  = 1'b1;
                    resp_data_d = bypass ? wr_data : mem_q[rd_req_flowid[gi]];
                end else if (rd_resp_rdy[gi]) begin
                    resp_val_d  = 1'b0;
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    resp_val_q  <= 1'b0;
                    resp_data_q <= '0;
                end else begin
                    resp_val_q  <= resp_val_d;
                    resp_data_q <= resp_data_d;
                end
            end

            assign rd_resp_val[gi]  = resp_val_q;
            assign rd_resp_data[gi] = resp_data_q;
        end
    endgenerate

endmodule

// File: tb/tb_rx_commit_ptr_table.sv
// Scoreboard bench for rx_commit_ptr_table: stimulus pushes expected read data
// into per-port queues, a negedge monitor pops and compares on each response.
`timescale 1ns/1ps

module tb_rx_commit_ptr_table;

    localparam int FW = 8;
    localparam int DW = 17;

    typedef struct packed {
        logic          sr_v;
        logic [FW-1:0] sr_f;
        logic          sr_rr;
        logic          ar_v;
        logic [FW-1:0] ar_f;
        logic          ar_rr;
        logic          sw_v;
        logic [FW-1:0] sw_f;
        logic [DW-1:0] sw_d;
        logic          in_v;
        logic [FW-1:0] in_f;
        logic [DW-1:0] in_d;
    } stim_t;

    logic          clk;
    logic          rst;
    logic          sbr_val;
    logic [FW-1:0] sbr_flow;
    logic          sbr_rdy;
    logic          sb_rval;
    logic [DW-1:0] sb_rdata;
    logic          sb_rrdy;
    logic          sbw_val;
    logic [FW-1:0] sbw_flow;
    logic [DW-1:0] sbw_data;
    logic          sbw_rdy;
    logic          apr_val;
    logic [FW-1:0] apr_flow;
    logic          apr_rdy;
    logic          ap_rval;
    logic [DW-1:0] ap_rdata;
    logic          ap_rrdy;
    logic          ini_val;
    logic [FW-1:0] ini_flow;
    logic [DW-1:0] ini_data;
    logic          ini_rdy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] model [1<<FW];
    logic [DW-1:0] sq [$];
    logic [DW-1:0] aq [$];

    rx_commit_ptr_table #(.FLOWID_W(FW), .RX_PAYLOAD_PTR_W(DW-1)) dut (
        .clk                                 (clk),
        .rst                                 (rst),
        .store_buf_commit_ptr_rd_req_val     (sbr_val),
        .store_buf_commit_ptr_rd_req_flowid  (sbr_flow),
        .commit_ptr_store_buf_rd_req_rdy     (sbr_rdy),
        .commit_ptr_store_buf_rd_resp_val    (sb_rval),
        .commit_ptr_store_buf_rd_resp_data   (sb_rdata),
        .store_buf_commit_ptr_rd_resp_rdy    (sb_rrdy),
        .store_buf_commit_ptr_wr_req_val     (sbw_val),
        .store_buf_commit_ptr_wr_req_flowid  (sbw_flow),
        .store_buf_commit_ptr_wr_req_data    (sbw_data),
        .commit_ptr_store_buf_wr_req_rdy     (sbw_rdy),
        .app_commit_ptr_rd_req_val           (apr_val),
        .app_commit_ptr_rd_req_flowid        (apr_flow),
        .commit_ptr_app_rd_req_rdy           (apr_rdy),
        .commit_ptr_app_rd_resp_val          (ap_rval),
        .commit_ptr_app_rd_resp_data         (ap_rdata),
        .app_commit_ptr_rd_resp_rdy          (ap_rrdy),
        .init_commit_ptr_wr_val              (ini_val),
        .init_commit_ptr_wr_flowid           (ini_flow),
        .init_commit_ptr_wr_data             (ini_data),
        .commit_ptr_init_wr_rdy              (ini_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s       = '0;
        s.sr_rr = 1'b1;
        s.ar_rr = 1'b1;
        return s;
    endfunction

    task automatic clear_inputs();
        sbr_val = 0; sbr_flow = '0; sb_rrdy = 1;
        apr_val = 0; apr_flow = '0; ap_rrdy = 1;
        sbw_val = 0; sbw_flow = '0; sbw_data = '0;
        ini_val = 0; ini_flow = '0; ini_data = '0;
    endtask

    // One clock of stimulus; the reference model decides acceptance and expected data.
    task automatic step(input stim_t s, output logic sw_acc);
        logic          we;
        logic [FW-1:0] wa;
        logic [DW-1:0] wd;
        @(posedge clk);
        #1;
        sbr_val = s.sr_v; sbr_flow = s.sr_f; sb_rrdy = s.sr_rr;
        apr_val = s.ar_v; apr_flow = s.ar_f; ap_rrdy = s.ar_rr;
        sbw_val = s.sw_v; sbw_flow = s.sw_f; sbw_data = s.sw_d;
        ini_val = s.in_v; ini_flow = s.in_f; ini_data = s.in_d;
        #6;
        chk("init_wr_rdy", ini_rdy, 1);
        chk("sb_wr_rdy", sbw_rdy, !s.in_v);
        chk("sb_rd_rdy", sbr_rdy, sq.size() == 0);
        chk("app_rd_rdy", apr_rdy, aq.size() == 0);
        we     = s.in_v | s.sw_v;
        wa     = s.in_v ? s.in_f : s.sw_f;
        wd     = s.in_v ? s.in_d : s.sw_d;
        sw_acc = s.sw_v & !s.in_v;
        if (s.sr_v && sq.size() == 0) sq.push_back((we && wa == s.sr_f) ? wd : model[s.sr_f]);
        if (s.ar_v && aq.size() == 0) aq.push_back((we && wa == s.ar_f) ? wd : model[s.ar_f]);
        if (we) model[wa] = wd;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("sb_resp_val", sb_rval, sq.size() != 0);
            if (sb_rval && sq.size() != 0) begin
                chk("sb_resp_data", sb_rdata, sq[0]);
                if (sb_rrdy) begin
                    $display("sb  rsp data=%h", sb_rdata);
                    void'(sq.pop_front());
                end
            end
            chk("app_resp_val", ap_rval, aq.size() != 0);
            if (ap_rval && aq.size() != 0) begin
                chk("app_resp_data", ap_rdata, aq[0]);
                if (ap_rrdy) begin
                    $display("app rsp data=%h", ap_rdata);
                    void'(aq.pop_front());
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_sb_rval"}, sb_rval, 0);
        chk({tag, "_ap_rval"}, ap_rval, 0);
        chk({tag, "_sb_rdata"}, sb_rdata, 0);
        chk({tag, "_ap_rdata"}, ap_rdata, 0);
        chk({tag, "_sb_rd_rdy"}, sbr_rdy, 1);
        chk({tag, "_ap_rd_rdy"}, apr_rdy, 1);
        chk({tag, "_sb_wr_rdy"}, sbw_rdy, 1);
        chk({tag, "_init_rdy"}, ini_rdy, 1);
    endtask

    initial begin
        stim_t s;
        logic  acc;
        logic  sw_pend;
        rst = 1'b0;
        clear_inputs();
        #12;
        check_reset_outputs("por");
        #11;
        rst = 1'b1;

        for (int f = 0; f < (1 << FW); f++) begin
            s = idle(); s.in_v = 1; s.in_f = FW'(f); s.in_d = DW'($urandom);
            step(s, acc);
        end

        // Init flow 5, then read it from both ports in the same cycle.
        s = idle(); s.in_v = 1; s.in_f = 5; s.in_d = 17'h0_0100; step(s, acc);
        s = idle(); s.sr_v = 1; s.sr_f = 5; s.ar_v = 1; s.ar_f = 5; step(s, acc);
        s = idle(); step(s, acc);

        // Stalled response on flow 3 while flow 3 is rewritten.
        s = idle(); s.sr_v = 1; s.sr_f = 3; s.sr_rr = 0; step(s, acc);
        for (int i = 0; i < 4; i++) begin
            s = idle(); s.sr_v = 1; s.sr_f = 3; s.sr_rr = 0;
            if (i == 1) begin s.sw_v = 1; s.sw_f = 3; s.sw_d = 17'h1_FFFF; end
            step(s, acc);
        end
        s = idle(); s.sr_v = 1; s.sr_f = 3; step(s, acc);
        s = idle(); step(s, acc);

        // Bypass from both write sources.
        s = idle(); s.ar_v = 1; s.ar_f = 7; s.sw_v = 1; s.sw_f = 7; s.sw_d = 17'h0_1234; step(s, acc);
        chk("bypass_sw_acc", acc, 1);
        s = idle(); s.sr_v = 1; s.sr_f = 8; s.in_v = 1; s.in_f = 8; s.in_d = 17'h1_0A5A; step(s, acc);

        // Init priority over a store-buf write.
        s = idle(); s.in_v = 1; s.in_f = 2; s.in_d = 17'h0; s.sw_v = 1; s.sw_f = 9; s.sw_d = 17'h0_0040;
        step(s, acc);
        s = idle(); s.sw_v = 1; s.sw_f = 9; s.sw_d = 17'h0_0040; step(s, acc);
        s = idle(); s.sr_v = 1; s.sr_f = 2; s.ar_v = 1; s.ar_f = 9; step(s, acc);
        s = idle(); step(s, acc);

        // Back-to-back reads of flows 0..15.
        for (int f = 0; f < 16; f++) begin
            s = idle(); s.sr_v = 1; s.sr_f = FW'(f); s.ar_v = 1; s.ar_f = FW'(15 - f);
            step(s, acc);
        end
        s = idle(); step(s, acc);

        // Asynchronous reset while a response is held.
        s = idle(); s.sr_v = 1; s.sr_f = 4; s.sr_rr = 0; s.ar_v = 1; s.ar_f = 6; s.ar_rr = 0; step(s, acc);
        s = idle(); s.sr_rr = 0; s.ar_rr = 0; step(s, acc);
        @(posedge clk);
        #3;
        rst = 1'b0;
        clear_inputs();
        #1;
        check_reset_outputs("mid");
        sq.delete();
        aq.delete();
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        s = idle(); s.sr_v = 1; s.sr_f = 4; s.ar_v = 1; s.ar_f = 4; step(s, acc);
        s = idle(); step(s, acc);

        // Randomized traffic with a collision-heavy flow range.
        sw_pend = 0;
        for (int i = 0; i < 1500; i++) begin
            stim_t p;
            p = s;
            s = idle();
            s.sr_rr = ($urandom_range(0, 3) != 0);
            s.ar_rr = ($urandom_range(0, 3) != 0);
            s.sr_v  = ($urandom_range(0, 1) != 0);
            s.sr_f  = FW'($urandom_range(0, 31));
            s.ar_v  = ($urandom_range(0, 1) != 0);
            s.ar_f  = FW'($urandom_range(0, 31));
            if (sw_pend) begin
                s.sw_v = 1; s.sw_f = p.sw_f; s.sw_d = p.sw_d;
            end else begin
                s.sw_v = ($urandom_range(0, 2) == 0);
                s.sw_f = FW'($urandom_range(0, 31));
                s.sw_d = DW'($urandom);
            end
            s.in_v = ($urandom_range(0, 5) == 0);
            s.in_f = FW'($urandom_range(0, 31));
            s.in_d = DW'($urandom);
            step(s, acc);
            sw_pend = s.sw_v & !acc;
        end

        for (int i = 0; i < 4; i++) begin
            s = idle(); step(s, acc);
        end
        @(posedge clk);
        #7;
        chk("sb_drained", sq.size(), 0);
        chk("app_drained", aq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rx_commit_ptr_table.md
# rx_commit_ptr_table

Per-flow receive commit-pointer table for the TCP receive pipe. Holds one (RX_PAYLOAD_PTR_W+1)-bit commit pointer per flow, including the wrap bit. The payload store-buffer copy engine uses it for read-modify-write: read commit pointer, copy payload, write the advanced pointer. The application-side read port uses it to learn how much in-order payload is available. Flow setup initialises entries through a dedicated init port.

## Interface
- FLOWID_W, 8: flow ID width; table depth is 2^FLOWID_W.
- RX_PAYLOAD_PTR_W, 16: payload buffer pointer width; stored entries are RX_PAYLOAD_PTR_W+1 bits.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset, asynchronous, active-low.
- store_buf_commit_ptr_rd_req_val  in  1  store-buf read request.
- store_buf_commit_ptr_rd_req_flowid  in  FLOWID_W  flow to read.
- commit_ptr_store_buf_rd_req_rdy  out  1  read request accepted.
- commit_ptr_store_buf_rd_resp_val  out  1  read response valid.
- commit_ptr_store_buf_rd_resp_data  out  RX_PAYLOAD_PTR_W+1  pointer read.
- store_buf_commit_ptr_rd_resp_rdy  in  1  response consumed.
- store_buf_commit_ptr_wr_req_val  in  1  store-buf write request.
- store_buf_commit_ptr_wr_req_flowid  in  FLOWID_W  flow to write.
- store_buf_commit_ptr_wr_req_data  in  RX_PAYLOAD_PTR_W+1  new pointer.
- commit_ptr_store_buf_wr_req_rdy  out  1  write accepted.
- app_commit_ptr_rd_req_val / _flowid / commit_ptr_app_rd_req_rdy  in / in / out  1 / FLOWID_W / 1  application read request.
- commit_ptr_app_rd_resp_val / _data / app_commit_ptr_rd_resp_rdy  out / out / in  1 / RX_PAYLOAD_PTR_W+1 / 1  application read response.
- init_commit_ptr_wr_val / _flowid / _data  in  1 / FLOWID_W / RX_PAYLOAD_PTR_W+1  flow-setup initialisation write.
- commit_ptr_init_wr_rdy  out  1  init write accepted.

## Operation
- Storage is 2R1W: two independent read ports (store-buf, app) and one write port. Entry contents are undefined after reset. Every flow must be initialised through the init port before use; the table does not clear entries on reset.
- Write arbitration: the init write has fixed priority.
  - commit_ptr_init_wr_rdy is always 1 out of reset.
  - commit_ptr_store_buf_wr_req_rdy = ~init_commit_ptr_wr_val.
  - At most one write commits per cycle, at the clock edge where val&rdy.
- Read ports are identical and independent. Each has a 1-entry response register:
  - rd_req_rdy = ~resp_val | resp_rdy.
  - On req_val&req_rdy, the response register loads the entry and resp_val sets next cycle.
  - resp_val clears on resp_rdy when no new request is accepted in the same cycle.
- Write-to-read bypass: if a read is accepted in the same cycle that a write commits to the same flowid, the response carries the newly written data. This applies to both ports and both write sources.
- Held responses are snapshots. A write to a flow whose response is stalled (resp_val=1, resp_rdy=0) does not alter the held data.
- Pointer arithmetic is done by the clients. The table stores and returns the full RX_PAYLOAD_PTR_W+1 bits verbatim, wrap bit included, with no masking.

## Timing
- Reset (rst=0, asynchronous): both resp_val=0, both rd_req_rdy=1, both write rdy=1, response data=0. Reset asserted mid-transaction drops any pending response. The first request after release is accepted in the first clock with rst=1.
- Read latency: request accepted at edge T gives resp_val=1 in cycle T+1. Throughput is 1 read per cycle per port when resp_rdy is held at 1.
- Write latency: a write committed at edge T is visible to a read accepted at edge T via bypass, and to all later reads.
- Store-buf write is blocked in any cycle with init_commit_ptr_wr_val=1. val and payload must stay stable until accepted.
- Both read ports may address the same flow in the same cycle; both get identical data.
- Only registered state drives outputs, except the rdy signals, which are combinational from resp_val/resp_rdy/init_val.

## Test plan
- Init flow 5 to 0x0_0100, then store-buf read flow 5 -> resp_val next cycle with data 0x0_0100; app read of flow 5 on the same cycle returns 0x0_0100.
- Store-buf read flow 3 with resp_rdy=0 for 4 cycles, while a write of flow 3 = 0x1_FFFF occurs -> held response keeps the old value; rd_req_rdy=0 until consumed; the next read returns 0x1_FFFF.
- Same-cycle write of flow 7 = 0x0_1234 and app read of flow 7 -> response 0x0_1234 (bypass).
- Same-cycle init write (flow 2 = 0) and store-buf write (flow 9 = 0x0_0040) -> init commits, store-buf rdy=0; store-buf write commits the next cycle; reads confirm flow 2=0 and flow 9=0x0_0040.
- Back-to-back reads of flows 0..15 with resp_rdy=1 -> 16 responses on consecutive cycles, in order, matching a reference model.
- Assert rst low while resp_val=1 -> resp_val=0 immediately (asynchronously); after release, both rd_req_rdy=1 and the next read completes normally.
